// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA SRAM read path.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int READ_LATENCY = 1;
    localparam int SKID_DEPTH   = 2;

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_fifo2
// Description : Two-entry FIFO that buffers SRAM read data for the stream
//               output; simultaneous push and pop are both honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    // The head register is the output, so it only changes on push-to-empty or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_din;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_din;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dout      = r_head;
    assign o_valid     = (r_count != 2'd0);
    assign o_occupancy = r_count;

endmodule
`default_nettype wire

// File: rtl/ssram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ssram_stream_reader
// Description : Burst reader for one port of a synchronous SRAM; delivers the
//               words as a valid/ready stream with credit-based issue.
//               Optional macro SSRAM_READER_LAST_EN adds the dataLast output.
// Revision    : 1.0 - initial release
// ============================================================================
module ssram_stream_reader
    import dma_pkg::*;
#(
    parameter  int BITWIDTH      = 32,
    parameter  int NR_OF_ENTRIES = 512,
    localparam int AW            = $clog2(NR_OF_ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       startAddress,
    input  logic [AW:0]         blockSize,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       ramAddress,
    output logic                ramWriteEnable,
    input  logic [BITWIDTH-1:0] ramDataOut,
    output logic [BITWIDTH-1:0] dataOut,
    output logic                dataValid,
    input  logic                dataReady
`ifdef SSRAM_READER_LAST_EN
    ,
    output logic                dataLast
`endif
);

`ifdef SSRAM_READER_LAST_EN
    localparam int c_fifo_w = BITWIDTH + 1;
`else
    localparam int c_fifo_w = BITWIDTH;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_addr;
    logic [AW-1:0]           w_addr_inc;
    logic [AW:0]             r_remaining;
    logic [READ_LATENCY-1:0] r_issue_pipe;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic [1:0]              w_occ;
    logic [2:0]              w_inflight;
    logic [2:0]              w_credit;
    logic [c_fifo_w-1:0]     w_fifo_din;
    logic [c_fifo_w-1:0]     w_fifo_dout;

    assign w_pop      = dataValid & dataReady;
    assign w_push     = r_issue_pipe[READ_LATENCY-1];
    assign w_inflight = 3'($countones(r_issue_pipe));
    // Words that will still be held after this cycle if nothing new is issued.
    assign w_credit   = {1'b0, w_occ} + w_inflight - {2'b00, w_pop};
    assign w_issue    = (r_state == READ) && (r_remaining != '0) &&
                        (w_credit < 3'(SKID_DEPTH));
    assign w_addr_inc = (r_addr == AW'(NR_OF_ENTRIES - 1)) ? '0 : r_addr + AW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (blockSize == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_issue && (r_remaining == (AW+1)'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_credit == 3'd0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_issue_pipe <= '0;
            ramAddress   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_issue_pipe <= READ_LATENCY'({r_issue_pipe, w_issue});
            if ((r_state == IDLE) && start) begin
                r_addr      <= startAddress;
                r_remaining <= blockSize;
            end else if (w_issue) begin
                ramAddress  <= r_addr;
                r_addr      <= w_addr_inc;
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

`ifdef SSRAM_READER_LAST_EN
    logic [READ_LATENCY-1:0] r_last_pipe;

    // The last-word tag travels alongside the read so it lands with its data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_pipe <= '0;
        end else begin
            r_last_pipe <= READ_LATENCY'({r_last_pipe,
                                          w_issue && (r_remaining == (AW+1)'(1))});
        end
    end

    assign w_fifo_din = {r_last_pipe[READ_LATENCY-1], ramDataOut};
    assign dataLast   = dataValid & w_fifo_dout[BITWIDTH];
`else
    assign w_fifo_din = ramDataOut;
`endif

    stream_skid_fifo2 #(
        .WIDTH (c_fifo_w)
    ) u_skid (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push),
        .i_din       (w_fifo_din),
        .i_pop       (w_pop),
        .o_dout      (w_fifo_dout),
        .o_valid     (dataValid),
        .o_occupancy (w_occ)
    );

    assign dataOut        = w_fifo_dout[BITWIDTH-1:0];
    assign busy           = (r_state == READ) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign ramWriteEnable = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ssram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssram_stream_reader
// Description : Scoreboard bench for ssram_stream_reader; directed bursts with
//               a queue of expected words checked by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssram_stream_reader;

    localparam int BW = 32;
    localparam int NE = 512;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] startAddress = '0;
    logic [AW:0]   blockSize = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ramAddress;
    logic          ramWriteEnable;
    logic [BW-1:0] ramDataOut;
    logic [BW-1:0] dataOut;
    logic          dataValid;
    logic          dataReady = 1'b1;
`ifdef SSRAM_READER_LAST_EN
    logic          dataLast;
`endif

    logic [BW-1:0] mem [NE];

    always #5 clock = ~clock;

    // The registered ramAddress acts as the SRAM's address register, so data
    // is presented in the cycle following the issue decision.
    assign ramDataOut = mem[ramAddress];

    ssram_stream_reader #(
        .BITWIDTH      (BW),
        .NR_OF_ENTRIES (NE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .startAddress   (startAddress),
        .blockSize      (blockSize),
        .busy           (busy),
        .done           (done),
        .ramAddress     (ramAddress),
        .ramWriteEnable (ramWriteEnable),
        .ramDataOut     (ramDataOut),
        .dataOut        (dataOut),
        .dataValid      (dataValid),
        .dataReady      (dataReady)
`ifdef SSRAM_READER_LAST_EN
        ,
        .dataLast       (dataLast)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hs_total = 0;
    int            last_hs_cyc = -10;
    int            done_seen = 0;
    int            burst_base = 0;
    logic [AW-1:0] burst_start = '0;
    bit            expect_words = 1'b0;
    bit            ahead_chk = 1'b0;
    bit            ready_mode = 1'b0;
    logic [BW:0]   exp_q [$];
    bit            stall_prev = 1'b0;
    logic [BW-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, pops the scoreboard on handshakes.
    always @(negedge clock) begin
        logic [BW:0]   e;
        logic [AW-1:0] off;
        int            issued;
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", dataValid, 1);
                chk("hold_data", dataOut, stall_data);
            end
            if (done) begin
                done_seen++;
                chk("done_busy", busy, 0);
                chk("done_queue_empty", exp_q.size(), 0);
                if (expect_words) chk("done_after_last", cyc - last_hs_cyc, 1);
            end
            if (ahead_chk && busy && (hs_total - burst_base) >= 1) begin
                off    = ramAddress - burst_start;
                issued = int'(off) + 1;
                chk("issue_ahead", (issued - (hs_total - burst_base)) <= 2, 1);
            end
`ifdef SSRAM_READER_LAST_EN
            if (!dataValid) chk("last_idle", dataLast, 0);
`endif
            if (dataValid && dataReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", dataOut);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", dataOut, e[BW-1:0]);
`ifdef SSRAM_READER_LAST_EN
                    chk("last", dataLast, e[BW]);
`endif
                end
                last_hs_cyc = cyc;
                hs_total++;
            end
            stall_prev = dataValid && !dataReady;
            stall_data = dataOut;
        end
    end

    // Consumer: always ready, or the repeating 1,0,0,1 pattern.
    initial begin
        int         idx;
        logic [3:0] pat;
        idx = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clock);
            #1;
            dataReady = ready_mode ? pat[idx] : 1'b1;
            idx = (idx + 1) % 4;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_burst(input int addr, input int size);
        logic [BW:0] e;
        for (int i = 0; i < size; i++) begin
            e = {(i == size - 1), mem[(addr + i) % NE]};
            exp_q.push_back(e);
        end
        burst_start  = AW'(addr);
        burst_base   = hs_total;
        expect_words = (size != 0);
        startAddress = AW'(addr);
        blockSize    = (AW+1)'(size);
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        bit got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk(name, got, 1);
        if (got) begin
            @(posedge clock);
            #1;
            chk({name, "_pulse"}, done, 0);
        end
    endtask

    initial begin
        int  ds;
        bit  reached;
        for (int i = 0; i < NE; i++) mem[i] = BW'(i + 'h100);

        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ramAddress, 0);
        chk("rst_valid", dataValid, 0);
        chk("rst_data", dataOut, 0);
        chk("rst_we", ramWriteEnable, 0);

        // Full-rate burst with latency checks
        do_burst(4, 8);
        chk("t1_busy", busy, 1);
        chk("t1_valid_n0", dataValid, 0);
        idle(1);
        chk("t1_addr_n1", ramAddress, 4);
        chk("t1_valid_n1", dataValid, 0);
        idle(1);
        chk("t1_valid_n2", dataValid, 1);
        chk("t1_first", dataOut, 'h104);
        wait_done(20, "t1_done");
        chk("t1_queue", exp_q.size(), 0);

        // Backpressure pattern
        idle(2);
        ready_mode = 1'b1;
        ahead_chk  = 1'b1;
        do_burst(4, 8);
        wait_done(80, "t2_done");
        ready_mode = 1'b0;
        ahead_chk  = 1'b0;
        chk("t2_queue", exp_q.size(), 0);

        // Address wrap
        idle(2);
        do_burst(NE - 2, 4);
        wait_done(20, "t3_done");
        chk("t3_queue", exp_q.size(), 0);
        chk("t3_addr_end", ramAddress, 1);

        // Zero-length burst
        idle(2);
        ds = done_seen;
        do_burst(5, 0);
        chk("t4_valid", dataValid, 0);
        wait_done(4, "t4_done");
        idle(2);
        chk("t4_addr", ramAddress, 1);
        chk("t4_valid_end", dataValid, 0);
        chk("t4_done_count", done_seen - ds, 1);

        // Reset during a burst
        idle(2);
        ds = done_seen;
        do_burst(4, 8);
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((hs_total - burst_base) >= 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("t5_three_words", reached, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        chk("t5_busy", busy, 0);
        chk("t5_valid", dataValid, 0);
        idle(3);
        chk("t5_no_done", done_seen - ds, 0);
        chk("t5_valid_idle", dataValid, 0);
        do_burst(20, 2);
        wait_done(20, "t5_done");
        chk("t5_queue", exp_q.size(), 0);
        chk("t5_done_count", done_seen - ds, 1);

`ifdef SSRAM_READER_LAST_EN
        // Last flag and start ignored while busy
        idle(2);
        do_burst(0, 3);
        startAddress = AW'(100);
        blockSize    = (AW+1)'(5);
        start        = 1'b1;
        idle(1);
        start = 1'b0;
        wait_done(20, "t6_done");
        idle(4);
        chk("t6_queue", exp_q.size(), 0);
        chk("t6_valid", dataValid, 0);
        chk("t6_busy", busy, 0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
